// File: rtl/jtframe_dwnld_pkg.sv
// Shared definitions for the ROM-download front end: swizzle modes, byte-lane
// mask codes and the per-region address bit permutation.
package jtframe_dwnld_pkg;

  typedef enum logic [1:0] {
    SWZ_ID   = 2'd0,
    SWZ_NIB  = 2'd1,
    SWZ_OBJ  = 2'd2,
    SWZ_LANE = 2'd3
  } swz_mode_e;

  localparam logic [1:0] MASK_LO = 2'b10;
  localparam logic [1:0] MASK_HI = 2'b01;

  // Permutes the low six byte-address bits; bit 0 of the result is the byte lane
  function automatic logic [5:0] swz(input swz_mode_e mode, input logic [5:0] a);
    case (mode)
      SWZ_ID:   swz = a;
      SWZ_NIB:  swz = {a[5:4], a[2:0], ~a[3]};
      SWZ_OBJ:  swz = {a[5], a[2:0], ~a[4], ~a[3]};
      SWZ_LANE: swz = {a[5:1], ~a[0]};
      default:  swz = a;
    endcase
  endfunction

endpackage

// File: rtl/jtframe_dwnld_swz_if.sv
// SDRAM writer handshake: one byte per request, held until the writer acks it.
interface jtframe_dwnld_swz_if #(
  parameter int AW = 22
);
  logic [AW-2:0] prog_addr;
  logic [7:0]    prog_data;
  logic [1:0]    prog_mask;
  logic          prog_we;
  logic          sdram_ack;

  modport master (
    output prog_addr, prog_data, prog_mask, prog_we,
    input  sdram_ack
  );

  modport slave (
    input  prog_addr, prog_data, prog_mask, prog_we,
    output sdram_ack
  );
endinterface

// File: rtl/jtframe_dwnld_fifo.sv
// Single-clock queue with full/empty flags; a push at full is accepted only
// when a pop frees a slot in the same cycle.
module jtframe_dwnld_fifo #(
  parameter int W     = 30,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic [W-1:0] din,
  input  logic         pop,
  output logic [W-1:0] dout,
  output logic         full,
  output logic         empty
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = PW + 1;

  logic [W-1:0]  mem_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          push_ok_s;
  logic          pop_ok_s;

  assign empty     = (count_r == {CW{1'b0}});
  assign full      = (count_r == CW'(DEPTH));
  assign pop_ok_s  = pop & ~empty;
  assign push_ok_s = push & (~full | pop_ok_s);
  assign dout      = mem_r[rd_ptr_r];

  // Storage array; contents are only observed while the queue is non-empty
  always_ff @(posedge clk) begin
    if (push_ok_s) begin
      mem_r[wr_ptr_r] <= din;
    end
  end

  // Pointers and occupancy count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (push_ok_s) begin
        wr_ptr_r <= wr_ptr_r + PW'(1);
      end
      if (pop_ok_s) begin
        rd_ptr_r <= rd_ptr_r + PW'(1);
      end
      case ({push_ok_s, pop_ok_s})
        2'b10:   count_r <= count_r + CW'(1);
        2'b01:   count_r <= count_r - CW'(1);
        default: count_r <= count_r;
      endcase
    end
  end

endmodule

// File: rtl/jtframe_dwnld_swz.sv
// ROM-download front end: each ioctl byte is matched to an SDRAM region,
// bit-swizzled and queued for the SDRAM writer, or sent out as a PROM strobe.
module jtframe_dwnld_swz
  import jtframe_dwnld_pkg::*;
#(
  parameter int                    REGIONS    = 3,
  parameter int                    AW         = 22,
  parameter logic [REGIONS*AW-1:0] REG_START  = {22'h18000, 22'h10000, 22'h0},
  parameter logic [REGIONS*2-1:0]  REG_MODE   = {2'd2, 2'd1, 2'd0},
  parameter logic [24:0]           PROM_START = 25'h1F000,
  parameter int                    PROM_AW    = 11,
  parameter int                    QDEPTH     = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   downloading,
  input  logic [24:0]            ioctl_addr,
  input  logic [7:0]             ioctl_dout,
  input  logic                   ioctl_wr,
  jtframe_dwnld_swz_if.master    prog,
  output logic                   prom_we,
  output logic [PROM_AW-1:0]     prom_addr,
  output logic [7:0]             prom_data,
  output logic                   dwnld_busy,
  output logic                   overflow
);

  localparam int EW = AW + 8;

  logic              region_hit_s;
  swz_mode_e         region_mode_s;
  logic              prom_hit_s;
  logic              write_s;
  logic              sdram_wr_s;
  logic              prom_wr_s;
  logic [AW-1:0]     swz_addr_s;

  logic              s1_valid_r;
  logic [AW-1:0]     s1_addr_r;
  logic [7:0]        s1_data_r;
  logic              s2_valid_r;
  logic [EW-1:0]     s2_entry_r;

  logic              prom_we_r;
  logic [PROM_AW-1:0] prom_addr_r;
  logic [7:0]        prom_data_r;
  logic              busy_r;
  logic              overflow_r;

  logic [EW-1:0]     head_s;
  logic              full_s;
  logic              empty_s;
  logic [AW-2:0]     prog_addr_s;
  logic [7:0]        prog_data_s;
  logic [1:0]        prog_mask_s;

  // Region comparator chain: the last base not above the address wins
  always_comb begin
    region_hit_s  = 1'b0;
    region_mode_s = SWZ_ID;
    for (int i = 0; i < REGIONS; i++) begin
      if (ioctl_addr >= 25'(REG_START[i*AW +: AW])) begin
        region_hit_s  = 1'b1;
        region_mode_s = swz_mode_e'(REG_MODE[i*2 +: 2]);
      end else begin
        region_hit_s  = region_hit_s;
        region_mode_s = region_mode_s;
      end
    end
    prom_hit_s = (ioctl_addr >= PROM_START);
    swz_addr_s = {ioctl_addr[AW-1:6], swz(region_mode_s, ioctl_addr[5:0])};
  end

  assign write_s    = downloading & ioctl_wr;
  assign sdram_wr_s = write_s & region_hit_s & ~prom_hit_s;
  assign prom_wr_s  = write_s & prom_hit_s;

  // Stage 1 (SDRAM hit and swizzled address) and the PROM strobe
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r  <= 1'b0;
      s1_addr_r   <= {AW{1'b0}};
      s1_data_r   <= 8'h00;
      prom_we_r   <= 1'b0;
      prom_addr_r <= {PROM_AW{1'b0}};
      prom_data_r <= 8'h00;
    end else begin
      s1_valid_r <= sdram_wr_s;
      if (sdram_wr_s) begin
        s1_addr_r <= swz_addr_s;
        s1_data_r <= ioctl_dout;
      end
      prom_we_r <= prom_wr_s;
      if (prom_wr_s) begin
        prom_addr_r <= PROM_AW'(ioctl_addr - PROM_START);
        prom_data_r <= ioctl_dout;
      end
    end
  end

  // Stage 2 packs {word address, byte, lane}; it drains even after downloading falls
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid_r <= 1'b0;
      s2_entry_r <= {EW{1'b0}};
    end else begin
      s2_valid_r <= s1_valid_r;
      s2_entry_r <= {s1_addr_r[AW-1:1], s1_data_r, s1_addr_r[0]};
    end
  end

  jtframe_dwnld_fifo #(
    .W     (EW),
    .DEPTH (QDEPTH)
  ) u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (s2_valid_r),
    .din   (s2_entry_r),
    .pop   (prog.sdram_ack),
    .dout  (head_s),
    .full  (full_s),
    .empty (empty_s)
  );

  // Sticky drop flag and busy status
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow_r <= 1'b0;
      busy_r     <= 1'b0;
    end else begin
      overflow_r <= overflow_r | (s2_valid_r & full_s & ~prog.sdram_ack);
      busy_r     <= downloading | s1_valid_r | s2_valid_r | ~empty_s;
    end
  end

  // Queue head onto the writer bus; idle bus reads as all zeros
  always_comb begin
    if (empty_s) begin
      prog_addr_s = {(AW-1){1'b0}};
      prog_data_s = 8'h00;
      prog_mask_s = 2'b00;
    end else begin
      prog_addr_s = head_s[EW-1:9];
      prog_data_s = head_s[8:1];
      prog_mask_s = head_s[0] ? MASK_HI : MASK_LO;
    end
  end

  assign prog.prog_we   = ~empty_s;
  assign prog.prog_addr = prog_addr_s;
  assign prog.prog_data = prog_data_s;
  assign prog.prog_mask = prog_mask_s;

  assign prom_we    = prom_we_r;
  assign prom_addr  = prom_addr_r;
  assign prom_data  = prom_data_r;
  assign dwnld_busy = busy_r;
  assign overflow   = overflow_r;

endmodule

// File: tb/tb_jtframe_dwnld_swz.sv
// Directed and randomized checks of jtframe_dwnld_swz against a queue-based
// reference model built from the region/swizzle rules.
module tb_jtframe_dwnld_swz;

  localparam int AW      = 22;
  localparam int PROM_AW = 11;
  localparam int QDEPTH  = 4;

  typedef struct {
    int          due;
    logic [20:0] addr;
    logic [7:0]  data;
    logic        lane;
  } ent_t;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic               downloading = 1'b0;
  logic [24:0]        ioctl_addr = 25'd0;
  logic [7:0]         ioctl_dout = 8'd0;
  logic               ioctl_wr = 1'b0;
  logic               prom_we;
  logic [PROM_AW-1:0] prom_addr;
  logic [7:0]         prom_data;
  logic               dwnld_busy;
  logic               overflow;

  int checks = 0;
  int errors = 0;

  ent_t        exp_q[$];
  ent_t        pend[$];
  ent_t        e;
  logic        exp_ovf;
  logic        prom_due;
  logic [10:0] prom_exp_addr;
  logic [7:0]  prom_exp_data;
  logic [24:0] ra;
  logic [7:0]  rd;
  logic        rw;
  logic        rk;
  logic [21:0] sw;

  jtframe_dwnld_swz_if #(.AW(AW)) prog_bus ();

  jtframe_dwnld_swz #(
    .AW      (AW),
    .PROM_AW (PROM_AW),
    .QDEPTH  (QDEPTH)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .downloading (downloading),
    .ioctl_addr  (ioctl_addr),
    .ioctl_dout  (ioctl_dout),
    .ioctl_wr    (ioctl_wr),
    .prog        (prog_bus),
    .prom_we     (prom_we),
    .prom_addr   (prom_addr),
    .prom_data   (prom_data),
    .dwnld_busy  (dwnld_busy),
    .overflow    (overflow)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic write(input logic [24:0] a, input logic [7:0] d);
    ioctl_addr = a;
    ioctl_dout = d;
    ioctl_wr   = 1'b1;
    tick();
    ioctl_wr   = 1'b0;
  endtask

  task automatic pop_check(input string tag, input logic [20:0] a, input logic [7:0] d,
                           input logic [1:0] m);
    int n = 0;
    while (prog_bus.prog_we !== 1'b1 && n < 8) begin
      tick();
      n++;
    end
    chk({tag, "_we"}, prog_bus.prog_we, 1);
    chk({tag, "_addr"}, prog_bus.prog_addr, a);
    chk({tag, "_data"}, prog_bus.prog_data, d);
    chk({tag, "_mask"}, prog_bus.prog_mask, m);
    prog_bus.sdram_ack = 1'b1;
    tick();
    prog_bus.sdram_ack = 1'b0;
  endtask

  // Byte address after region lookup and swizzle, from plain arithmetic
  function automatic logic [21:0] model_swz(input logic [24:0] a);
    int starts[3] = '{0, 'h10000, 'h18000};
    int modes[3]  = '{0, 1, 2};
    int m;
    int lo;
    logic [31:0] s;
    m  = 0;
    for (int i = 0; i < 3; i++) begin
      if (a >= 25'(starts[i])) m = modes[i];
    end
    lo = int'(a[5:0]);
    case (m)
      1:       s = 32'(((lo >> 3) & 1) ^ 1) + 32'((lo & 7) * 2) + 32'(lo & 48);
      2:       s = 32'(((lo >> 3) & 1) ^ 1) + 32'((((lo >> 4) & 1) ^ 1) * 2)
                   + 32'((lo & 7) * 4) + 32'(lo & 32);
      3:       s = 32'(lo & 62) + 32'((lo & 1) ^ 1);
      default: s = 32'(lo);
    endcase
    return {a[21:6], s[5:0]};
  endfunction

  initial begin
    prog_bus.sdram_ack = 1'b0;
    #1 rst_n = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;

    chk("rst_prog_we", prog_bus.prog_we, 0);
    chk("rst_prog_mask", prog_bus.prog_mask, 0);
    chk("rst_prom_we", prom_we, 0);
    chk("rst_busy", dwnld_busy, 0);
    chk("rst_overflow", overflow, 0);

    // Mode 1 with exact latency
    downloading = 1'b1;
    write(25'h10005, 8'hA5);
    chk("m1_we_n1", prog_bus.prog_we, 0);
    tick();
    chk("m1_we_n2", prog_bus.prog_we, 0);
    tick();
    chk("m1_we_n3", prog_bus.prog_we, 1);
    chk("m1_addr", prog_bus.prog_addr, 21'h8005);
    chk("m1_data", prog_bus.prog_data, 8'hA5);
    chk("m1_mask", prog_bus.prog_mask, 2'b01);
    prog_bus.sdram_ack = 1'b1;
    tick();
    prog_bus.sdram_ack = 1'b0;
    chk("m1_popped", prog_bus.prog_we, 0);

    // Mode 2
    write(25'h18000, 8'h3C);
    pop_check("m2a", 21'hC001, 8'h3C, 2'b01);
    write(25'h18018, 8'h5A);
    pop_check("m2b", 21'hC000, 8'h5A, 2'b10);

    // Push coinciding with a pop at full is accepted
    for (int i = 0; i < 4; i++) begin
      ioctl_addr = 25'(32'h20 + i);
      ioctl_dout = 8'(32'h20 + i);
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    repeat (3) tick();
    chk("full_head", prog_bus.prog_data, 8'h20);
    write(25'h24, 8'h24);
    tick();
    prog_bus.sdram_ack = 1'b1;
    tick();
    prog_bus.sdram_ack = 1'b0;
    chk("pp_no_ovf", overflow, 0);
    pop_check("pp1", 21'h10, 8'h21, 2'b01);
    pop_check("pp2", 21'h11, 8'h22, 2'b10);
    pop_check("pp3", 21'h11, 8'h23, 2'b01);
    pop_check("pp4", 21'h12, 8'h24, 2'b10);
    chk("pp_empty", prog_bus.prog_we, 0);

    // Six writes with no ack: four queued, two dropped
    for (int i = 0; i < 6; i++) begin
      ioctl_addr = 25'(i);
      ioctl_dout = 8'(i);
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    repeat (3) tick();
    chk("ovf_set", overflow, 1);
    chk("ovf_we", prog_bus.prog_we, 1);

    // PROM byte bypasses the full queue
    write(25'h1F010, 8'h7E);
    chk("prom_we", prom_we, 1);
    chk("prom_addr", prom_addr, 11'h010);
    chk("prom_data", prom_data, 8'h7E);
    tick();
    chk("prom_we_pulse", prom_we, 0);

    // Drain after end of download
    downloading = 1'b0;
    repeat (2) tick();
    chk("drain_busy_pre", dwnld_busy, 1);
    prog_bus.sdram_ack = 1'b1;
    for (int i = 0; i < 4; i++) begin
      chk("drain_we", prog_bus.prog_we, 1);
      chk("drain_data", prog_bus.prog_data, 32'(i));
      chk("drain_addr", prog_bus.prog_addr, 32'(i / 2));
      chk("drain_mask", prog_bus.prog_mask, (i % 2 == 1) ? 2'b01 : 2'b10);
      tick();
    end
    chk("drain_empty", prog_bus.prog_we, 0);
    chk("drain_busy_hold", dwnld_busy, 1);
    prog_bus.sdram_ack = 1'b0;
    tick();
    chk("drain_busy_fall", dwnld_busy, 0);
    chk("drain_ovf_sticky", overflow, 1);

    // Reset in mid-handshake
    downloading = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ioctl_addr = 25'(32'h30 + i);
      ioctl_dout = 8'(i);
      ioctl_wr   = 1'b1;
      tick();
    end
    ioctl_wr = 1'b0;
    repeat (3) tick();
    chk("mid_we", prog_bus.prog_we, 1);
    rst_n = 1'b0;
    #1;
    chk("arst_we", prog_bus.prog_we, 0);
    chk("arst_addr", prog_bus.prog_addr, 0);
    chk("arst_data", prog_bus.prog_data, 0);
    chk("arst_mask", prog_bus.prog_mask, 0);
    chk("arst_prom_addr", prom_addr, 0);
    chk("arst_busy", dwnld_busy, 0);
    chk("arst_ovf", overflow, 0);
    downloading = 1'b0;
    tick();
    rst_n = 1'b1;
    repeat (4) tick();
    chk("post_rst_we", prog_bus.prog_we, 0);
    chk("post_rst_ovf", overflow, 0);
    chk("post_rst_busy", dwnld_busy, 0);

    // Writes outside the download window are ignored
    write(25'h10005, 8'h11);
    write(25'h1F010, 8'h22);
    for (int i = 0; i < 4; i++) begin
      chk("idle_we", prog_bus.prog_we, 0);
      chk("idle_prom", prom_we, 0);
      chk("idle_busy", dwnld_busy, 0);
      tick();
    end

    // Randomized traffic against the reference queue
    downloading = 1'b1;
    exp_ovf  = 1'b0;
    prom_due = 1'b0;
    for (int c = 0; c < 400; c++) begin
      chk("rnd_we", prog_bus.prog_we, 32'(exp_q.size() != 0));
      if (exp_q.size() != 0) begin
        chk("rnd_addr", prog_bus.prog_addr, exp_q[0].addr);
        chk("rnd_data", prog_bus.prog_data, exp_q[0].data);
        chk("rnd_mask", prog_bus.prog_mask, exp_q[0].lane ? 2'b01 : 2'b10);
      end
      chk("rnd_prom_we", prom_we, prom_due);
      if (prom_due) begin
        chk("rnd_prom_addr", prom_addr, prom_exp_addr);
        chk("rnd_prom_data", prom_data, prom_exp_data);
      end
      chk("rnd_ovf", overflow, exp_ovf);

      rw = (c < 360) && ($urandom_range(0, 9) < 4);
      rk = (c >= 360) || ($urandom_range(0, 1) == 1);
      ra = 25'($urandom_range(0, 'h1FFFF));
      rd = 8'($urandom_range(0, 255));
      ioctl_addr = ra;
      ioctl_dout = rd;
      ioctl_wr   = rw;
      prog_bus.sdram_ack = rk;

      if (rk && exp_q.size() != 0) void'(exp_q.pop_front());
      if (pend.size() != 0 && pend[0].due == c) begin
        e = pend.pop_front();
        if (exp_q.size() < QDEPTH) exp_q.push_back(e);
        else exp_ovf = 1'b1;
      end
      prom_due = 1'b0;
      if (rw) begin
        if (ra >= 25'h1F000) begin
          prom_due      = 1'b1;
          prom_exp_addr = 11'(ra - 25'h1F000);
          prom_exp_data = rd;
        end else begin
          sw     = model_swz(ra);
          e.due  = c + 2;
          e.addr = sw[21:1];
          e.lane = sw[0];
          e.data = rd;
          pend.push_back(e);
        end
      end
      tick();
    end
    ioctl_wr = 1'b0;
    prog_bus.sdram_ack = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
